// File: rtl/activation_readout_streamer.sv
// activation_readout_streamer: reads rows from the activation memory
// and streams each row out as message-width slices, LSB slice first.
module activation_readout_streamer #(
  parameter int ACTIVATION_WORD_BIT_WIDTH = 64,
  parameter int ACTIVATION_ROWS           = 32,
  parameter int MESSAGE_BIT_WIDTH         = 32,
  parameter int READ_LATENCY              = 1,
  localparam int ADDR_W = $clog2(ACTIVATION_ROWS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ADDR_W-1:0]                    start_row,
  input  logic [ADDR_W:0]                      num_rows,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 mem_read_enable,
  output logic [ADDR_W-1:0]                    mem_address_read,
  input  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] mem_data_out,
  output logic                                 msg_valid,
  input  logic                                 msg_ready,
  output logic [MESSAGE_BIT_WIDTH-1:0]         msg_data
);

  localparam int MSGS  = ACTIVATION_WORD_BIT_WIDTH / MESSAGE_BIT_WIDTH;
  localparam int SL_W  = (MSGS > 1) ? $clog2(MSGS) : 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t                          r_state;
  logic [ADDR_W-1:0]               r_row;
  logic [CNT_W-1:0]                r_left;
  logic [SL_W-1:0]                 r_slice;
  logic [LAT_W-1:0]                r_wait;
  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] r_shift;
  logic                            r_re;
  logic [ADDR_W-1:0]               r_addr;
  logic                            r_valid;
  logic                            r_done;

  logic [CNT_W-1:0]  w_num_sat;
  logic [ADDR_W-1:0] w_next_row;
  logic              w_last_slice;
  logic              w_hs;

  assign w_num_sat = (num_rows > CNT_W'(ACTIVATION_ROWS))
                   ? CNT_W'(ACTIVATION_ROWS) : num_rows;
  assign w_next_row = (r_row == ADDR_W'(ACTIVATION_ROWS - 1))
                    ? '0 : r_row + 1'b1;
  assign w_last_slice = (r_slice == SL_W'(MSGS - 1));
  assign w_hs = r_valid && msg_ready;

  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign mem_read_enable  = r_re;
  assign mem_address_read = r_addr;
  assign msg_valid        = r_valid;
  assign msg_data         = r_shift[MESSAGE_BIT_WIDTH-1:0];

  // Transfer FSM: read a row, wait out memory latency, stream its slices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_left  <= '0;
      r_slice <= '0;
      r_wait  <= '0;
      r_shift <= '0;
      r_re    <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_re    <= 1'b0;
        r_valid <= 1'b0;
        r_left  <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              if (num_rows == '0) begin
                r_done <= 1'b1;
              end else begin
                r_row   <= start_row;
                r_addr  <= start_row;
                r_left  <= w_num_sat;
                r_re    <= 1'b1;
                r_state <= S_READ;
              end
            end
          end
          S_READ: begin
            r_re    <= 1'b0;
            r_wait  <= LAT_W'(1);
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (r_wait == LAT_W'(READ_LATENCY)) begin
              r_shift <= mem_data_out;
              r_slice <= '0;
              r_valid <= 1'b1;
              r_state <= S_STREAM;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          S_STREAM: begin
            if (w_hs) begin
              if (!w_last_slice) begin
                r_slice <= r_slice + 1'b1;
                r_shift <= r_shift >> MESSAGE_BIT_WIDTH;
              end else begin
                r_valid <= 1'b0;
                if (r_left > CNT_W'(1)) begin
                  r_left  <= r_left - 1'b1;
                  r_row   <= w_next_row;
                  r_addr  <= w_next_row;
                  r_re    <= 1'b1;
                  r_state <= S_READ;
                end else begin
                  r_left  <= '0;
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
                end
              end
            end
          end
          S_FINISH: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_activation_readout_streamer.sv
// tb_activation_readout_streamer: directed checks of the row streamer
// with a latency-modelled memory, plus a READ_LATENCY=3 instance.
module tb_activation_readout_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [4:0]  start_row = '0;
  logic [5:0]  num_rows = '0;
  logic        abort = 1'b0;
  logic        busy, done, re, valid;
  logic [4:0]  addr;
  logic [63:0] mdo;
  logic        ready = 1'b0;
  logic [31:0] data;

  logic        s3_start = 1'b0;
  logic        s3_busy, s3_done, s3_re, s3_valid;
  logic [4:0]  s3_addr;
  logic [63:0] s3_mdo;
  logic [31:0] s3_data;

  logic [63:0] mem [32];
  logic [63:0] pa [1];
  logic [63:0] pb [3];

  activation_readout_streamer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .start_row(start_row), .num_rows(num_rows),
    .abort(abort), .busy(busy), .done(done),
    .mem_read_enable(re), .mem_address_read(addr),
    .mem_data_out(mdo), .msg_valid(valid),
    .msg_ready(ready), .msg_data(data)
  );

  activation_readout_streamer #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start),
    .start_row(5'd7), .num_rows(6'd1),
    .abort(1'b0), .busy(s3_busy), .done(s3_done),
    .mem_read_enable(s3_re), .mem_address_read(s3_addr),
    .mem_data_out(s3_mdo), .msg_valid(s3_valid),
    .msg_ready(1'b1), .msg_data(s3_data)
  );

  always @(posedge clk) begin
    pa[0] <= mem[addr];
    pb[0] <= mem[s3_addr];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign mdo    = pa[0];
  assign s3_mdo = pb[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] got_q [$];
  int addr_q [$];
  int ndone, done_cyc, first_valid, stall_err, abort_cyc;
  bit aborted;
  logic ab_busy, ab_valid, ab_re;

  task automatic run(input int sr, input int nr, input int pct,
                     input bit poke, input int abort_idx);
    int cyc;
    int post;
    bit prev_stall;
    logic [31:0] prev_data;
    got_q.delete();
    addr_q.delete();
    ndone = 0; done_cyc = -1; first_valid = -1;
    stall_err = 0; aborted = 0; abort_cyc = -10;
    ab_busy = 1'bx; ab_valid = 1'bx; ab_re = 1'bx;
    start = 1; start_row = 5'(sr); num_rows = 6'(nr); ready = 0;
    @(negedge clk);
    start = 0;
    cyc = 1; post = -1; prev_stall = 0; prev_data = '0;
    while (cyc < 2000 && post != 0) begin
      abort = 0; start = 0;
      if (aborted && cyc == abort_cyc + 1) begin
        ab_busy = busy; ab_valid = valid; ab_re = re;
      end
      if (re) addr_q.push_back(int'(addr));
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!valid || data !== prev_data)) stall_err++;
      ready = ($urandom_range(99) < pct);
      if (abort_idx >= 0 && !aborted && valid &&
          got_q.size() == abort_idx) begin
        abort = 1; ready = 1; aborted = 1;
        abort_cyc = cyc; post = 8;
      end else if (valid && ready) begin
        got_q.push_back(data);
      end
      if (poke && cyc == 4) begin
        start = 1; start_row = 5'd0; num_rows = 6'd1;
      end
      prev_stall = valid && !ready;
      prev_data = data;
      if (post < 0 && ndone > 0) post = 3;
      else if (post > 0) post--;
      @(negedge clk);
      cyc++;
    end
    abort = 0; start = 0; ready = 0;
    chk("no_timeout", cyc < 2000, 1);
  endtask

  task automatic check_stream(input string tag, input int sr,
                              input int nrow);
    chk({tag, "_nmsg"}, got_q.size(), 2 * nrow);
    chk({tag, "_nread"}, addr_q.size(), nrow);
    for (int r = 0; r < nrow; r++) begin
      int row;
      row = (sr + r) % 32;
      if (r < addr_q.size()) chk({tag, "_addr"}, addr_q[r], row);
      for (int k = 0; k < 2; k++)
        if (2 * r + k < got_q.size())
          chk({tag, "_msg"}, got_q[2*r+k], mem[row][32*k +: 32]);
    end
  endtask

  initial begin
    int cyc;
    for (int r = 0; r < 32; r++)
      mem[r] = {32'hA000_0000 + 32'(r), 32'hC000_0000 + 32'(r)};
    mem[5] = 64'h1122_3344_5566_7788;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", re, 0);
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    rst_n = 1;
    @(negedge clk);

    // single row, LSB slice first
    run(5, 1, 100, 0, -1);
    chk("t1_n", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_m0", got_q[0], 32'h5566_7788);
      chk("t1_m1", got_q[1], 32'h1122_3344);
    end
    chk("t1_first_valid", first_valid, 3);
    chk("t1_done_cyc", done_cyc, 5);
    chk("t1_ndone", ndone, 1);
    chk("t1_busy_end", busy, 0);

    // wrap-around
    run(30, 4, 100, 0, -1);
    check_stream("t2", 30, 4);
    chk("t2_ndone", ndone, 1);

    // backpressure
    run(12, 6, 70, 0, -1);
    check_stream("t3", 12, 6);
    chk("t3_stall_stable", stall_err, 0);
    chk("t3_ndone", ndone, 1);

    // zero rows
    run(3, 0, 100, 0, -1);
    chk("t4_zero_done_cyc", done_cyc, 1);
    chk("t4_zero_ndone", ndone, 1);
    chk("t4_zero_reads", addr_q.size(), 0);

    // saturating count
    run(0, 40, 100, 0, -1);
    check_stream("t4_sat", 0, 32);
    chk("t4_sat_ndone", ndone, 1);

    // start while busy is ignored
    run(10, 3, 100, 1, -1);
    check_stream("t4_poke", 10, 3);
    chk("t4_poke_ndone", ndone, 1);

    // abort on 2nd slice of 2nd row
    run(20, 3, 100, 0, 3);
    chk("t5_aborted", aborted, 1);
    chk("t5_busy", ab_busy, 0);
    chk("t5_valid", ab_valid, 0);
    chk("t5_re", ab_re, 0);
    chk("t5_ndone", ndone, 0);
    chk("t5_nmsg", got_q.size(), 3);
    chk("t5_nread", addr_q.size(), 2);
    run(8, 1, 100, 0, -1);
    check_stream("t5_restart", 8, 1);
    chk("t5_restart_ndone", ndone, 1);

    // async reset mid-stream
    start = 1; start_row = 5'd2; num_rows = 6'd2; ready = 0;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_reached_stream", valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", valid, 0);
    chk("t6_re", re, 0);
    chk("t6_addr", addr, 0);
    chk("t6_data", data, 0);
    chk("t6_done", done, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // READ_LATENCY=3 instance
    s3_start = 1;
    @(negedge clk);
    s3_start = 0;
    cyc = 1;
    while (!s3_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_lat3_first_valid", cyc, 5);
    chk("t6_lat3_data", s3_data, mem[7][31:0]);

    // transfer after reset still works
    run(31, 2, 100, 0, -1);
    check_stream("t6_after", 31, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
